// File: rtl/control_unit_ws.sv
// Multi-cycle control FSM for the K&S datapath: fetch, decode and sequence LOAD/STORE/ALU/branch/halt.
// Outputs decode the registered state. RAM accesses stretch by MEM_WAIT cycles. There is no backpressure.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;
endpackage

module control_unit_ws
  import k_and_s_pkg::*;
#(
  parameter int MEM_WAIT  = 0,
  parameter bit OV_SIGNED = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    write_reg_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic [1:0]              operation,
  output logic                    halt,
  output logic [CNT_W-1:0]        retired
);

  if (MEM_WAIT < 0 || MEM_WAIT > 15) begin : g_mem_wait_range
    $error("control_unit_ws: MEM_WAIT must be within 0..15");
  end

  typedef enum logic [2:0] {
    S_FETCH,
    S_LOAD_IR,
    S_DECODE,
    S_EXEC,
    S_MEM_LOAD,
    S_MEM_STORE,
    S_BRANCH,
    S_HALT
  } state_t;

  // FETCH occupies max(1, MEM_WAIT) cycles; data accesses occupy MEM_WAIT+1.
  localparam logic [3:0] MEM_LAST   = 4'(MEM_WAIT);
  localparam logic [3:0] FETCH_LAST = (MEM_WAIT == 0) ? 4'd0 : 4'(MEM_WAIT - 1);

  state_t           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [1:0]       exec_op_q, exec_op_d;
  logic             exec_flg_q, exec_flg_d;

  logic ovf;
  logic mem_last;
  logic fetch_last;
  logic retire;

  assign ovf        = OV_SIGNED ? signed_overflow : unsigned_overflow;
  assign mem_last   = (wait_q == MEM_LAST);
  assign fetch_last = (wait_q == FETCH_LAST);
  assign retired    = retired_q;

  always_comb begin
    state_d    = state_q;
    exec_op_d  = exec_op_q;
    exec_flg_d = exec_flg_q;
    retire     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (fetch_last) state_d = S_LOAD_IR;
      end
      S_LOAD_IR: state_d = S_DECODE;
      S_DECODE: begin
        // ALU op is captured here so EXEC does not depend on the IR staying stable.
        case (decoded_instruction)
          I_HALT:   begin state_d = S_HALT; retire = 1'b1; end
          I_LOAD:   state_d = S_MEM_LOAD;
          I_STORE:  state_d = S_MEM_STORE;
          I_ADD:    begin state_d = S_EXEC; exec_op_d = 2'b01; exec_flg_d = 1'b1; end
          I_SUB:    begin state_d = S_EXEC; exec_op_d = 2'b10; exec_flg_d = 1'b1; end
          I_AND:    begin state_d = S_EXEC; exec_op_d = 2'b11; exec_flg_d = 1'b1; end
          I_OR:     begin state_d = S_EXEC; exec_op_d = 2'b00; exec_flg_d = 1'b1; end
          I_MOVE:   begin state_d = S_EXEC; exec_op_d = 2'b00; exec_flg_d = 1'b0; end
          I_BRANCH: state_d = S_BRANCH;
          I_BZERO:  if (zero_op)  state_d = S_BRANCH; else begin state_d = S_FETCH; retire = 1'b1; end
          I_BNZERO: if (!zero_op) state_d = S_BRANCH; else begin state_d = S_FETCH; retire = 1'b1; end
          I_BNEG:   if (neg_op)   state_d = S_BRANCH; else begin state_d = S_FETCH; retire = 1'b1; end
          I_BNNEG:  if (!neg_op)  state_d = S_BRANCH; else begin state_d = S_FETCH; retire = 1'b1; end
          I_BOV:    if (ovf)      state_d = S_BRANCH; else begin state_d = S_FETCH; retire = 1'b1; end
          I_BNOV:   if (!ovf)     state_d = S_BRANCH; else begin state_d = S_FETCH; retire = 1'b1; end
          default:  begin state_d = S_FETCH; retire = 1'b1; end
        endcase
      end
      S_EXEC:      begin state_d = S_FETCH; retire = 1'b1; end
      S_MEM_LOAD:  if (mem_last) begin state_d = S_FETCH; retire = 1'b1; end
      S_MEM_STORE: if (mem_last) begin state_d = S_FETCH; retire = 1'b1; end
      S_BRANCH:    begin state_d = S_FETCH; retire = 1'b1; end
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase

    // Counter restarts on each state entry and sticks at its top value.
    if (state_d != state_q)  wait_d = 4'd0;
    else if (wait_q == 4'hF) wait_d = wait_q;
    else                     wait_d = wait_q + 4'd1;

    if (retire && (retired_q != {CNT_W{1'b1}})) retired_d = retired_q + CNT_W'(1);
    else                                        retired_d = retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_q     <= 4'd0;
      retired_q  <= '0;
      exec_op_q  <= 2'b00;
      exec_flg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      retired_q  <= retired_d;
      exec_op_q  <= exec_op_d;
      exec_flg_q <= exec_flg_d;
    end
  end

  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    write_reg_enable = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    operation        = 2'b00;
    halt             = 1'b0;
    unique case (state_q)
      S_FETCH: ;
      S_LOAD_IR: begin
        ir_enable = 1'b1;
        pc_enable = 1'b1;
      end
      S_DECODE: begin
        addr_sel = (decoded_instruction == I_LOAD) || (decoded_instruction == I_STORE);
      end
      S_EXEC: begin
        write_reg_enable = 1'b1;
        c_sel            = 1'b1;
        operation        = exec_op_q;
        flags_reg_enable = exec_flg_q;
      end
      S_MEM_LOAD: begin
        addr_sel         = 1'b1;
        write_reg_enable = mem_last;
      end
      S_MEM_STORE: begin
        addr_sel         = 1'b1;
        ram_write_enable = mem_last;
      end
      S_BRANCH: begin
        branch    = 1'b1;
        pc_enable = 1'b1;
      end
      S_HALT: halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit_ws.sv
// Bench for control_unit_ws: two parameterisations driven by a per-cycle expected trace built from instruction-level rules.
module tb_control_unit_ws;
  import k_and_s_pkg::*;

  localparam logic [10:0] V_HALT = 11'h400, V_BR  = 11'h200, V_PC  = 11'h100, V_IR  = 11'h080;
  localparam logic [10:0] V_WR   = 11'h040, V_ADR = 11'h020, V_CS  = 11'h010, V_FLG = 11'h008;
  localparam logic [10:0] V_RAM  = 11'h004;

  typedef struct {
    decoded_instruction_type ins;
    logic [3:0]              fl;
    logic [10:0]             vec;
    int                      ret;
  } cyc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  decoded_instruction_type instr = I_NOP;
  logic zero_op = 1'b0, neg_op = 1'b0, uov = 1'b0, sov = 1'b0;

  logic br_a, pc_a, ir_a, wr_a, adr_a, cs_a, flg_a, ram_a, hlt_a;
  logic br_b, pc_b, ir_b, wr_b, adr_b, cs_b, flg_b, ram_b, hlt_b;
  logic [1:0]  op_a, op_b;
  logic [15:0] ret_a;
  logic [3:0]  ret_b;

  control_unit_ws #(.MEM_WAIT(0), .OV_SIGNED(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uov), .signed_overflow(sov),
    .branch(br_a), .pc_enable(pc_a), .ir_enable(ir_a), .write_reg_enable(wr_a),
    .addr_sel(adr_a), .c_sel(cs_a), .flags_reg_enable(flg_a), .ram_write_enable(ram_a),
    .operation(op_a), .halt(hlt_a), .retired(ret_a)
  );

  control_unit_ws #(.MEM_WAIT(3), .OV_SIGNED(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uov), .signed_overflow(sov),
    .branch(br_b), .pc_enable(pc_b), .ir_enable(ir_b), .write_reg_enable(wr_b),
    .addr_sel(adr_b), .c_sel(cs_b), .flags_reg_enable(flg_b), .ram_write_enable(ram_b),
    .operation(op_b), .halt(hlt_b), .retired(ret_b)
  );

  logic [10:0] vec_a, vec_b, obs_vec;
  logic [15:0] obs_ret;
  bit sel = 1'b0;
  assign vec_a   = {hlt_a, br_a, pc_a, ir_a, wr_a, adr_a, cs_a, flg_a, ram_a, op_a};
  assign vec_b   = {hlt_b, br_b, pc_b, ir_b, wr_b, adr_b, cs_b, flg_b, ram_b, op_b};
  assign obs_vec = sel ? vec_b : vec_a;
  assign obs_ret = sel ? 16'(ret_b) : ret_a;

  int wr_pulses_b = 0;
  always @(posedge wr_b) wr_pulses_b++;

  int    tests = 0, failed = 0;
  string tname = "";
  cyc_t  trace[$];
  int    exp_ret = 0, m_mw = 0, m_cw = 16, halt_cycles = 100;
  bit    m_ovs = 1'b0;

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  function automatic decoded_instruction_type rnd_ins(input int hi);
    logic [3:0] r;
    r = 4'($urandom_range(0, hi));
    return decoded_instruction_type'(r);
  endfunction

  task automatic setup(input bit which, input string nm);
    sel     = which;
    m_mw    = which ? 3 : 0;
    m_ovs   = which;
    m_cw    = which ? 4 : 16;
    exp_ret = 0;
    tname   = nm;
    trace.delete();
  endtask

  task automatic push(input decoded_instruction_type ins, input logic [3:0] fl,
                      input logic [10:0] v, input bit retire_now);
    cyc_t c;
    c.ins = ins; c.fl = fl; c.vec = v; c.ret = exp_ret;
    trace.push_back(c);
    if (retire_now && exp_ret < (1 << m_cw) - 1) exp_ret++;
  endtask

  // Appends the expected cycle-by-cycle behaviour of one instruction; fl={zero,neg,uov,sov} at decode.
  task automatic model_instr(input decoded_instruction_type ins, input logic [3:0] fl);
    int          fetch_n;
    bit          taken, ovf, is_cond;
    logic [10:0] ev;
    fetch_n = (m_mw == 0) ? 1 : m_mw;
    for (int i = 0; i < fetch_n; i++) push(ins, rnd4(), 11'd0, 1'b0);
    push(ins, rnd4(), V_IR | V_PC, 1'b0);
    ovf     = m_ovs ? fl[0] : fl[1];
    is_cond = 1'b1;
    taken   = 1'b0;
    case (ins)
      I_BZERO:  taken = fl[3];
      I_BNZERO: taken = !fl[3];
      I_BNEG:   taken = fl[2];
      I_BNNEG:  taken = !fl[2];
      I_BOV:    taken = ovf;
      I_BNOV:   taken = !ovf;
      default:  is_cond = 1'b0;
    endcase
    case (ins)
      I_HALT: begin
        push(ins, fl, 11'd0, 1'b1);
        for (int i = 0; i < halt_cycles; i++) push(rnd_ins(15), rnd4(), V_HALT, 1'b0);
      end
      I_LOAD, I_STORE: begin
        push(ins, fl, V_ADR, 1'b0);
        for (int k = 0; k <= m_mw; k++)
          push(ins, rnd4(), V_ADR | ((k == m_mw) ? ((ins == I_LOAD) ? V_WR : V_RAM) : 11'd0), k == m_mw);
      end
      I_ADD, I_SUB, I_AND, I_OR, I_MOVE: begin
        ev = V_WR | V_CS;
        if (ins != I_MOVE) ev = ev | V_FLG;
        if (ins == I_ADD) ev = ev | 11'd1;
        if (ins == I_SUB) ev = ev | 11'd2;
        if (ins == I_AND) ev = ev | 11'd3;
        push(ins, fl, 11'd0, 1'b0);
        push(ins, rnd4(), ev, 1'b1);
      end
      I_BRANCH: begin
        push(ins, fl, 11'd0, 1'b0);
        push(ins, rnd4(), V_BR | V_PC, 1'b1);
      end
      default: begin
        if (is_cond && taken) begin
          push(ins, fl, 11'd0, 1'b0);
          push(ins, rnd4(), V_BR | V_PC, 1'b1);
        end else begin
          push(ins, fl, 11'd0, 1'b1);
        end
      end
    endcase
  endtask

  // Resets, releases on a falling edge, then checks the first n trace cycles.
  task automatic run_trace(input int n);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < n && k < trace.size(); k++) begin
      if (k != 0) @(negedge clk);
      instr = trace[k].ins;
      {zero_op, neg_op, uov, sov} = trace[k].fl;
      #1;
      tests++;
      if (obs_vec !== trace[k].vec) begin
        failed++;
        $display("FAIL %s ctrl cycle %0d: got %b want %b (halt,br,pc,ir,wr,adr,csel,flg,ram,op)",
                 tname, k, obs_vec, trace[k].vec);
      end
      tests++;
      if (obs_ret !== 16'(trace[k].ret)) begin
        failed++;
        $display("FAIL %s retired cycle %0d: got %0d want %0d", tname, k, obs_ret, trace[k].ret);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr = rnd_ins(15);
    {zero_op, neg_op, uov, sov} = rnd4();
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (vec_a !== 11'd0) begin failed++; $display("FAIL reset ctrl_a: got %b want 0", vec_a); end
    tests++;
    if (vec_b !== 11'd0) begin failed++; $display("FAIL reset ctrl_b: got %b want 0", vec_b); end
    tests++;
    if (ret_a !== 16'd0) begin failed++; $display("FAIL reset retired_a: got %0d want 0", ret_a); end
    tests++;
    if (ret_b !== 4'd0) begin failed++; $display("FAIL reset retired_b: got %0d want 0", ret_b); end
  endtask

  task automatic test_add();
    setup(1'b0, "add");
    model_instr(I_ADD, rnd4());
    model_instr(I_SUB, rnd4());
    model_instr(I_AND, rnd4());
    model_instr(I_OR, rnd4());
    run_trace(trace.size());
  endtask

  task automatic test_store_wait();
    setup(1'b1, "store_wait");
    model_instr(I_STORE, rnd4());
    model_instr(I_LOAD, rnd4());
    run_trace(trace.size());
  endtask

  task automatic test_cond_branch();
    setup(1'b0, "cond_branch");
    model_instr(I_BZERO, {1'b1, 3'($urandom)});
    model_instr(I_BZERO, {1'b0, 3'($urandom)});
    model_instr(I_BRANCH, rnd4());
    for (int i = 0; i < 12; i++)
      model_instr(decoded_instruction_type'(4'(9 + (i % 6))), rnd4());
    run_trace(trace.size());
  endtask

  task automatic test_ov_select();
    setup(1'b0, "ov_unsigned");
    model_instr(I_BOV, {2'($urandom), 2'b01});
    model_instr(I_BNOV, {2'($urandom), 2'b01});
    run_trace(trace.size());
    setup(1'b1, "ov_signed");
    model_instr(I_BOV, {2'($urandom), 2'b01});
    model_instr(I_BNOV, {2'($urandom), 2'b01});
    run_trace(trace.size());
  endtask

  task automatic test_saturate();
    setup(1'b1, "saturate");
    for (int i = 0; i < 20; i++) model_instr(I_MOVE, rnd4());
    run_trace(trace.size());
    @(negedge clk);
    #1;
    tests++;
    if (obs_ret !== 16'd15) begin failed++; $display("FAIL saturate final retired: got %0d want 15", obs_ret); end
  endtask

  task automatic test_halt();
    setup(1'b0, "halt");
    model_instr(I_ADD, rnd4());
    model_instr(I_LOAD, rnd4());
    model_instr(I_HALT, rnd4());
    run_trace(trace.size());
  endtask

  task automatic test_reset_mid_load();
    int idx, base;
    setup(1'b1, "reset_mid_load");
    model_instr(I_ADD, rnd4());
    idx = trace.size() + m_mw + 2;
    model_instr(I_LOAD, rnd4());
    base = wr_pulses_b;
    run_trace(idx + 2);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (obs_vec !== 11'd0) begin failed++; $display("FAIL mid_load ctrl after reset: got %b want 0", obs_vec); end
    tests++;
    if (obs_ret !== 16'd0) begin failed++; $display("FAIL mid_load retired after reset: got %0d want 0", obs_ret); end
    repeat (2) @(negedge clk);
    tests++;
    if (wr_pulses_b - base !== 1) begin
      failed++;
      $display("FAIL mid_load wr pulses: got %0d want 1", wr_pulses_b - base);
    end
    setup(1'b1, "after_mid_load");
    model_instr(I_MOVE, rnd4());
    run_trace(trace.size());
  endtask

  task automatic test_reset_mid_store();
    int idx;
    setup(1'b1, "reset_mid_store");
    idx = m_mw + 2 + m_mw;
    model_instr(I_STORE, rnd4());
    run_trace(idx + 1);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (ram_b !== 1'b0) begin failed++; $display("FAIL mid_store ram_we after reset: got %b want 0", ram_b); end
    tests++;
    if (obs_vec !== 11'd0) begin failed++; $display("FAIL mid_store ctrl after reset: got %b want 0", obs_vec); end
  endtask

  task automatic test_random(input bit which);
    setup(which, which ? "random_b" : "random_a");
    for (int i = 0; i < 30; i++) model_instr(rnd_ins(14), rnd4());
    run_trace(trace.size());
  endtask

  initial begin
    test_reset();
    test_add();
    test_store_wait();
    test_cond_branch();
    test_ov_select();
    test_saturate();
    test_halt();
    test_reset_mid_load();
    test_reset_mid_store();
    test_random(1'b0);
    test_random(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/control_unit_ws.md
CONTROL_UNIT_WS -- requirements
Module: control_unit_ws

Interface
REQ-001 Parameter MEM_WAIT, default 0, meaning extra RAM read/write wait cycles (0..15) inserted before each memory access completes.
REQ-002 Parameter OV_SIGNED, default 0, meaning I_BOV/I_BNOV test signed_overflow when 1 and unsigned_overflow when 0.
REQ-003 Parameter CNT_W, default 16, meaning width of the retired-instruction counter.
REQ-004 Reset is rst_n, asynchronous, active-low; the clock is clk.
REQ-005 clk input 1 system clock; rst_n input 1 async active-low reset.
REQ-006 decoded_instruction input decoded_instruction_type (k_and_s_pkg): current instruction.
REQ-007 zero_op, neg_op, unsigned_overflow, signed_overflow input 1 each: registered ALU flags.
REQ-008 branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable, ram_write_enable output 1 each: datapath controls.
REQ-009 operation output 2: ALU op. 00 = OR/pass, 01 = ADD, 10 = SUB, 11 = AND.
REQ-010 halt output 1: program halted.
REQ-011 retired output CNT_W: count of completed instructions.

Function
REQ-012 FSM states: FETCH, LOAD_IR, DECODE, EXEC, MEM_LOAD, MEM_STORE, BRANCH, HALT; state and wait counter are registered, outputs are combinational from state.
REQ-013 All control outputs default 0 in every state unless stated below.
REQ-014 FETCH: addr_sel=0; stay MEM_WAIT cycles (wait counter), then go to LOAD_IR; with MEM_WAIT=0, FETCH lasts 1 cycle.
REQ-015 LOAD_IR: ir_enable=1, pc_enable=1 for exactly 1 cycle -> DECODE.
REQ-016 DECODE, 1 cycle, routes as follows.
  - I_HALT -> HALT.
  - I_LOAD -> MEM_LOAD; I_STORE -> MEM_STORE; addr_sel=1 in DECODE for both.
  - I_ADD/I_SUB/I_AND/I_OR/I_MOVE -> EXEC.
  - I_BRANCH -> BRANCH.
  - Conditional branches -> BRANCH when taken, else FETCH. Taken conditions: I_BZERO zero_op=1; I_BNZERO zero_op=0; I_BNEG neg_op=1; I_BNNEG neg_op=0; I_BOV selected overflow=1; I_BNOV selected overflow=0.
  - Any other value -> FETCH (treated as NOP).
REQ-017 EXEC, 1 cycle: write_reg_enable=1, c_sel=1, operation per REQ-009 (I_MOVE uses 00), flags_reg_enable=1 except for I_MOVE (0) -> FETCH.
REQ-018 MEM_LOAD: addr_sel=1 for MEM_WAIT+1 cycles; write_reg_enable=1, c_sel=0 only in the final cycle -> FETCH.
REQ-019 MEM_STORE: addr_sel=1 for MEM_WAIT+1 cycles; ram_write_enable=1 only in the final cycle (exactly 1 pulse per store) -> FETCH.
REQ-020 BRANCH, 1 cycle: branch=1, pc_enable=1 -> FETCH.
REQ-021 HALT: halt=1, all other controls 0; terminal until reset.
REQ-022 Wait counter is 4 bits, cleared on every state entry, never wraps; MEM_WAIT>15 is illegal (elaboration error).
REQ-023 retired increments by 1 on exit from EXEC, MEM_LOAD final cycle, MEM_STORE final cycle, BRANCH, a not-taken conditional branch or NOP decode, and on HALT entry; saturates at all-ones (no wrap).
REQ-024 Flags sampled in DECODE only; flag changes in other states have no effect.

Reset
REQ-025 rst_n=0 asynchronously forces state=FETCH, wait counter=0, retired=0; all outputs 0 while in reset.
REQ-026 Reset asserted mid-operation (any state, including MEM_STORE final cycle) aborts immediately; ram_write_enable drops combinationally with state.
REQ-027 First FETCH after rst_n release starts on the first rising clk edge with rst_n=1.

Verification
REQ-028 MEM_WAIT=0, I_ADD -> FETCH, LOAD_IR, DECODE, EXEC (4 cycles); EXEC drives operation=01, write_reg_enable=1, c_sel=1, flags_reg_enable=1; retired=1.
REQ-029 MEM_WAIT=3, I_STORE -> FETCH 3 cycles, MEM_STORE 4 cycles; ram_write_enable high exactly 1 cycle (the 4th); addr_sel=1 in DECODE and for all 4 MEM_STORE cycles.
REQ-030 I_BZERO with zero_op=1 -> BRANCH with branch=pc_enable=1; with zero_op=0 -> FETCH, branch never 1; retired increments in both cases.
REQ-031 OV_SIGNED=1, I_BOV with signed_overflow=1, unsigned_overflow=0 -> taken; OV_SIGNED=0 with the same flags -> not taken.
REQ-032 CNT_W=4, 20 I_MOVE instructions -> retired saturates at 15; flags_reg_enable stays 0 throughout.
REQ-033 I_HALT -> halt=1 held for 100 cycles; rst_n pulsed low mid MEM_LOAD -> state=FETCH, retired=0, write_reg_enable never pulsed.
